// File: rtl/key_pulse_gen.sv
// rtl/key_pulse_gen.sv - debounced, auto-repeating, priority-serialised button pulse generator
module key_pulse_gen #(
    parameter int DEBOUNCE      = 250000,
    parameter int REPEAT_DELAY  = 15000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_down,
    input  logic btn_rot,
    output logic left,
    output logic right,
    output logic down,
    output logic ro
);

    // Button index order doubles as service priority: 0 = left (highest) .. 3 = rotate.
    localparam logic [23:0] DB_LAST = 24'(DEBOUNCE - 1);
    localparam logic [23:0] RD_LAST = 24'(REPEAT_DELAY - 1);
    localparam logic [23:0] RP_LAST = 24'(REPEAT_PERIOD - 1);
    // Rotate never auto-repeats; its repeat counter still runs but its hits are masked.
    localparam logic [3:0]  REPEATS = 4'b0111;

    logic [3:0]  raw;
    logic [3:0]  sync1;
    logic [3:0]  sync2;
    logic [3:0]  deb;
    logic [3:0]  deb_prev;
    logic [3:0]  rep_phase;
    logic [3:0]  press;
    logic [3:0]  rep_hit;
    logic [3:0]  evt;
    logic [3:0]  pend;
    logic [3:0]  grant;
    logic [23:0] db_cnt  [4];
    logic [23:0] rep_cnt [4];

    // Event detection and fixed-priority selection of one pending flag.
    always_comb begin
        raw     = {btn_rot, btn_down, btn_right, btn_left};
        press   = deb & ~deb_prev;
        rep_hit = '0;
        for (int i = 0; i < 4; i++) begin
            if (deb[i]) begin
                rep_hit[i] = rep_phase[i] ? (rep_cnt[i] == RP_LAST)
                                          : (rep_cnt[i] == RD_LAST);
            end
        end
        evt   = press | (rep_hit & REPEATS);
        grant = '0;
        if (pend[0])      grant = 4'b0001;
        else if (pend[1]) grant = 4'b0010;
        else if (pend[2]) grant = 4'b0100;
        else if (pend[3]) grant = 4'b1000;
    end

    // Two-flop synchronizers, debounce filters and edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            deb_prev <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 24'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Hold-time counters: first hit after the initial delay, then once per period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_phase <= '0;
            for (int i = 0; i < 4; i++) rep_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!deb[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (rep_hit[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b1;
                end else begin
                    rep_cnt[i]   <= rep_cnt[i] + 24'd1;
                end
            end
        end
    end

    // Pending flags and registered one-hot pulses; a disabled gate flushes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend                     <= '0;
            {ro, down, right, left}  <= '0;
        end else if (en) begin
            pend                     <= (pend & ~grant) | evt;
            {ro, down, right, left}  <= grant;
        end else begin
            pend                     <= '0;
            {ro, down, right, left}  <= '0;
        end
    end

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb/tb_key_pulse_gen.sv - scoreboard bench for key_pulse_gen
module tb_key_pulse_gen;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    localparam logic [3:0] ID_L = 4'b0001;
    localparam logic [3:0] ID_R = 4'b0010;
    localparam logic [3:0] ID_D = 4'b0100;
    localparam logic [3:0] ID_O = 4'b1000;

    logic clk = 1'b0;
    logic rst, en, bl, br, bd, bo;
    logic left, right, down, ro;

    key_pulse_gen #(.DEBOUNCE(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .rst(rst), .en(en),
        .btn_left(bl), .btn_right(br), .btn_down(bd), .btn_rot(bo),
        .left(left), .right(right), .down(down), .ro(ro)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [3:0] id;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    task automatic expect_pulse(input int at, input logic [3:0] id);
        exp_t e;
        e.at = at;
        e.id = id;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_quiet(input string name);
        logic [3:0] o;
        o = {ro, down, right, left};
        checks++;
        if (o !== 4'b0000) begin
            failures++;
            $display("FAIL %s: outputs=%b required=0000", name, o);
        end
    endtask

    // Monitor: every asserted output must match the oldest expected pulse.
    always @(negedge clk) begin
        logic [3:0] o;
        exp_t e;
        o = {ro, down, right, left};
        if (rst === 1'b0 && o != 4'b0000) begin
            checks++;
            if ($countones(o) != 1) begin
                failures++;
                $display("FAIL onehot: outputs=%b at cycle %0d required exactly one high", o, cyc);
            end
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: outputs=%b at cycle %0d required none", o, cyc);
            end else begin
                e = q.pop_front();
                if (e.at != cyc || e.id != o) begin
                    failures++;
                    $display("FAIL pulse: got %b at cycle %0d required %b at cycle %0d",
                             o, cyc, e.id, e.at);
                end
            end
        end
    end

    initial begin
        int c;
        int r;
        rst = 1'b1; en = 1'b1; bl = 1'b0; br = 1'b0; bd = 1'b0; bo = 1'b0;
        idle(3);
        check_quiet("reset_outputs");
        rst = 1'b0;
        idle(3);
        check_quiet("post_reset_idle");

        // Left held 40 cycles: first pulse at c+D+4, repeats at c+27, c+35, c+43.
        @(negedge clk); bl = 1'b1; c = cyc;
        expect_pulse(c + 8,  ID_L);
        expect_pulse(c + 27, ID_L);
        expect_pulse(c + 35, ID_L);
        expect_pulse(c + 43, ID_L);
        idle(40); bl = 1'b0;
        idle(30);

        // Rotate bouncing every 2 cycles: shorter than debounce, no pulses.
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            bo = ~bo;
            idle(2);
        end
        bo = 1'b0;
        idle(20);

        // Left and rotate together: left first, rotate one cycle later.
        @(negedge clk); bl = 1'b1; bo = 1'b1; c = cyc;
        expect_pulse(c + 8, ID_L);
        expect_pulse(c + 9, ID_O);
        idle(6); bl = 1'b0; bo = 1'b0;
        idle(30);

        // Three buttons together: held flags served in priority order.
        @(negedge clk); bl = 1'b1; br = 1'b1; bd = 1'b1; c = cyc;
        expect_pulse(c + 8,  ID_L);
        expect_pulse(c + 9,  ID_R);
        expect_pulse(c + 10, ID_D);
        idle(6); bl = 1'b0; br = 1'b0; bd = 1'b0;
        idle(30);

        // Down pressed with en low; repeat event at c+33 after enabling gives pulse at c+35.
        @(negedge clk); en = 1'b0; bd = 1'b1; c = cyc;
        expect_pulse(c + 35, ID_D);
        idle(30); en = 1'b1;
        idle(4); bd = 1'b0;
        idle(30);

        // Reset mid-debounce discards the press; held button re-debounces afterwards.
        @(negedge clk); br = 1'b1;
        idle(3);
        #2 rst = 1'b1;
        #1 check_quiet("async_reset_outputs");
        idle(2);
        rst = 1'b0; r = cyc;
        expect_pulse(r + 8, ID_R);
        idle(12); br = 1'b0;
        idle(30);

        // Rotate held 100 cycles: exactly one pulse.
        @(negedge clk); bo = 1'b1; c = cyc;
        expect_pulse(c + 8, ID_O);
        idle(100); bo = 1'b0;
        idle(30);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL missing_pulses: %0d outstanding, next %b at cycle %0d, required 0 outstanding",
                     q.size(), q[0].id, q[0].at);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_pulse_gen.md
KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

Interface
REQ-001 Parameter DEBOUNCE, default 250000; consecutive stable cycles required to accept a level change (5 ms at 50 MHz).
REQ-002 Parameter REPEAT_DELAY, default 15000000; hold cycles before the first auto-repeat.
REQ-003 Parameter REPEAT_PERIOD, default 5000000; cycles between subsequent auto-repeats.
REQ-004 Port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1, asynchronous, active-high reset.
REQ-006 Port en, input, 1, synchronous gate; high allows pulses, low suppresses them (pause/game over).
REQ-007 Port btn_left, btn_right, btn_down, btn_rot, input, 1 each, raw asynchronous push-button levels, high = pressed.
REQ-008 Port left, right, down, ro, output, 1 each, registered single-cycle move/rotate request pulses to the downstream position-update stage.

Function
REQ-009 Each btn_* SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 Each button SHALL keep a debounced state and a 24-bit counter; the counter increments while the synchronized level differs from the debounced state and clears when they agree.
REQ-011 When the counter reaches DEBOUNCE-1 while still differing, the debounced state SHALL toggle and the counter clear on the same edge.
REQ-012 A press event is a debounced 0->1 transition; a release is a debounced 1->0 transition and generates no pulse.
REQ-013 Each button SHALL have a pending flag, set by a press event or a repeat event on the cycle after that event.
REQ-014 Each cycle with en=1, exactly one output SHALL be asserted for the highest-priority set pending flag (left > right > down > ro); that flag clears on the same edge.
REQ-015 At most one of left/right/down/ro SHALL be high in any cycle; each pulse lasts exactly one cycle.
REQ-016 Lower-priority pending flags SHALL be held, not dropped, until served.
REQ-017 If a new event sets a flag on the same edge that flag is served, the flag SHALL remain set (one further pulse follows).
REQ-018 Auto-repeat applies to left, right and down only; ro SHALL never repeat.
REQ-019 A per-button 24-bit repeat counter SHALL start at 0 on a press event, increment each cycle the debounced state is 1, and raise a repeat event at REPEAT_DELAY-1, then every REPEAT_PERIOD cycles thereafter.
REQ-020 The repeat counter SHALL clear on release; pending flags already set SHALL survive release.
REQ-021 With en=0, all outputs SHALL be 0 and all pending flags cleared every cycle; synchronizers, debounce and repeat counters keep running.
REQ-022 Latency: with no contention, raw press sampled on edge k, sync valid at k+2, the debounced toggle at k+1+DEBOUNCE, pending at k+2+DEBOUNCE, output pulse high during the cycle after edge k+3+DEBOUNCE.
REQ-023 A bounce shorter than DEBOUNCE cycles SHALL produce no pulse.

Reset
REQ-024 rst=1 SHALL immediately clear synchronizers, debounced states, all counters, pending flags and outputs to 0, independent of clk.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL discard the event; after release, a button still held SHALL be treated as a fresh press (full debounce, then one pulse).

Verification (DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, en=1 unless stated)
REQ-026 btn_left high for 40 cycles -> left pulses at press+DEBOUNCE+3, then about 20 cycles later, then every 8 cycles; no other output asserts.
REQ-027 btn_rot toggling every 2 cycles for 20 cycles, then low -> zero pulses on ro.
REQ-028 btn_left and btn_rot rise on the same edge, held 6 cycles -> left pulses on cycle N, ro on cycle N+1, never both high.
REQ-029 btn_down held 30 cycles with en=0 for the whole press -> no down pulse; en raised while still held -> next repeat event yields a down pulse.
REQ-030 rst asserted asynchronously between clock edges while btn_right is debouncing -> all outputs 0 immediately; after rst release with button held, right pulses DEBOUNCE+3 cycles later.
REQ-031 btn_rot held 100 cycles -> exactly one ro pulse.
